// File: rtl/frame_egress_ctrl.sv
// frame_egress_ctrl
//   Pops per-frame descriptors from the sideband FIFO and streams each frame
//   out of the frame buffer as an AXI-Stream byte stream tagged with its
//   destination. The committed read pointer handed back to the frame-buffer
//   writer only advances once a frame's last byte has been accepted, or when
//   a zero-length descriptor is discarded.
//
// Ports
//   clk, reset        : single clock, synchronous active-high reset
//   sb_empty/sb_ren   : sideband FIFO status / read strobe (rdata next cycle)
//   sb_rdata          : descriptor {zero pad, end pointer, dest}
//   fb_ren/fb_raddr   : frame buffer read port (data one cycle later)
//   fb_rdata          : frame buffer read data
//   fb_rptr           : committed read pointer (wrap bit in MSB)
//   m_t*              : AXI-Stream egress (data, valid, ready, last, dest)
module frame_egress_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DEST_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sb_empty,
  output logic                  sb_ren,
  input  logic [19:0]           sb_rdata,
  output logic                  fb_ren,
  output logic [ADDR_WIDTH-1:0] fb_raddr,
  input  logic [7:0]            fb_rdata,
  output logic [ADDR_WIDTH:0]   fb_rptr,
  output logic [7:0]            m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [DEST_WIDTH-1:0] m_tdest
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         end_ptr_q, end_ptr_d;
  logic [PW-1:0]         fb_rptr_q, fb_rptr_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic [DEST_WIDTH-1:0] tdest_q, tdest_d;

  // One read may be in flight; its last flag travels with it.
  logic infl_q, infl_last_q;

  // Two-entry output skid buffer.
  logic [7:0] sk_data_q [2];
  logic       sk_last_q [2];
  logic       sk_wr_q, sk_rd_q;
  logic [1:0] sk_cnt_q, sk_cnt_d;

  logic [PW-1:0]         desc_end;
  logic [DEST_WIDTH-1:0] desc_dest;
  logic                  pop, space_ok, fetch_en, tlast_hs;

  logic unused_sb_bits;
  assign unused_sb_bits = ^sb_rdata[19:ADDR_WIDTH+DEST_WIDTH+1];

  assign desc_end  = sb_rdata[ADDR_WIDTH+DEST_WIDTH:DEST_WIDTH];
  assign desc_dest = sb_rdata[DEST_WIDTH-1:0];

  assign m_tvalid = (sk_cnt_q != 2'd0);
  assign m_tdata  = m_tvalid ? sk_data_q[sk_rd_q] : 8'h00;
  assign m_tlast  = m_tvalid & sk_last_q[sk_rd_q];
  assign m_tdest  = tdest_q;
  assign fb_rptr  = fb_rptr_q;

  assign pop      = m_tvalid & m_tready;
  assign tlast_hs = pop & m_tlast;

  // Occupancy is counted after this cycle's pop so that a byte leaving and
  // a new read issuing can overlap, giving one byte per cycle.
  assign space_ok = ({1'b0, sk_cnt_q} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop});
  assign fetch_en = ((state_q == S_LOAD) || (state_q == S_STREAM)) &&
                    (rd_ptr_q != end_ptr_q) && space_ok;

  assign fb_ren   = fetch_en;
  assign fb_raddr = rd_ptr_q[ADDR_WIDTH-1:0];
  assign rd_ptr_d = rd_ptr_q + (fetch_en ? PTR_ONE : '0);
  assign sk_cnt_d = sk_cnt_q + {1'b0, infl_q} - {1'b0, pop};

  always_comb begin
    state_d   = state_q;
    sb_ren    = 1'b0;
    end_ptr_d = end_ptr_q;
    dest_d    = dest_q;
    tdest_d   = tdest_q;
    fb_rptr_d = fb_rptr_q;
    case (state_q)
      S_IDLE: begin
        if (!sb_empty) begin
          sb_ren  = 1'b1;
          state_d = S_POP;
        end
      end
      S_POP: begin
        end_ptr_d = desc_end;
        dest_d    = desc_dest;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        // The first read of a non-empty frame issues here via fetch_en.
        if (end_ptr_q == rd_ptr_q) begin
          fb_rptr_d = end_ptr_q;
          state_d   = S_IDLE;
        end else begin
          tdest_d = dest_q;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (rd_ptr_q == end_ptr_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Popping the next descriptor on the tlast beat skips IDLE.
        if (tlast_hs) begin
          fb_rptr_d = end_ptr_q;
          if (!sb_empty) begin
            sb_ren  = 1'b1;
            state_d = S_POP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      end_ptr_q   <= '0;
      fb_rptr_q   <= '0;
      dest_q      <= '0;
      tdest_q     <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      sk_cnt_q    <= 2'd0;
      sk_wr_q     <= 1'b0;
      sk_rd_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      end_ptr_q   <= end_ptr_d;
      fb_rptr_q   <= fb_rptr_d;
      dest_q      <= dest_d;
      tdest_q     <= tdest_d;
      infl_q      <= fetch_en;
      infl_last_q <= ((rd_ptr_q + PTR_ONE) == end_ptr_q);
      sk_cnt_q    <= sk_cnt_d;
      if (infl_q) sk_wr_q <= ~sk_wr_q;
      if (pop)    sk_rd_q <= ~sk_rd_q;
    end
  end

  // Skid storage holds data only; validity lives in sk_cnt_q.
  always_ff @(posedge clk) begin
    if (infl_q) begin
      sk_data_q[sk_wr_q] <= fb_rdata;
      sk_last_q[sk_wr_q] <= infl_last_q;
    end
  end

endmodule

// File: tb/tb_frame_egress_ctrl.sv
// Testbench for frame_egress_ctrl: sideband FIFO and frame-buffer models,
// table-driven frame vectors, hand-written multi-cycle sequences and a
// randomized phase checked against a byte-stream reference model.
module tb_frame_egress_ctrl;
  localparam int AW = 11;
  localparam int DW = 2;

  logic          clk = 1'b0;
  logic          reset, sb_empty, sb_ren, fb_ren, m_tvalid, m_tready, m_tlast;
  logic [19:0]   sb_rdata;
  logic [AW-1:0] fb_raddr;
  logic [7:0]    fb_rdata, m_tdata;
  logic [AW:0]   fb_rptr;
  logic [DW-1:0] m_tdest;

  always #5 clk = ~clk;

  frame_egress_ctrl #(.ADDR_WIDTH(AW), .DEST_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .sb_empty(sb_empty), .sb_ren(sb_ren),
    .sb_rdata(sb_rdata), .fb_ren(fb_ren), .fb_raddr(fb_raddr),
    .fb_rdata(fb_rdata), .fb_rptr(fb_rptr), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tdest(m_tdest)
  );

  typedef struct {
    logic [7:0]  data;
    logic        last;
    logic [1:0]  dest;
    logic [11:0] fend;
  } beat_t;

  typedef struct {
    logic [1:0]  dest;
    logic [11:0] fend;
    int          mode;        // 0: ready=1, 1: pattern 1,0,0,1, 2: random
    int          exp_beats;
    logic [10:0] exp_first;
    logic [10:0] exp_last;
    logic [11:0] exp_rptr;
    int          exp_lat;
  } vec_t;

  logic [7:0]  mem [2048];
  logic [19:0] sb_q [$];
  beat_t       exp_q [$];
  logic [11:0] model_ptr, model_rptr;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int n_beats, n_tlast, n_fbren, n_valid, first_valid_cyc;
  int sbren_cyc [$];
  int hs_cyc [$];
  int tlast_beat [$];
  logic [1:0]  beat_dest [$];
  logic [10:0] first_addr, last_addr;
  logic        seen_fbren, seen_valid;

  logic        s_sb_ren, s_fb_ren;
  logic [10:0] s_addr;
  logic        prev_stall, prev_rst;
  logic [7:0]  prev_data;
  logic        prev_last;
  logic [1:0]  prev_dest;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic reset_stats();
    n_beats = 0; n_tlast = 0; n_fbren = 0; n_valid = 0; first_valid_cyc = 0;
    sbren_cyc.delete(); hs_cyc.delete(); tlast_beat.delete(); beat_dest.delete();
    seen_fbren = 1'b0; seen_valid = 1'b0; first_addr = '0; last_addr = '0;
  endtask

  // Reference model: a descriptor expands into the byte sequence it names.
  task automatic push_desc(input logic [1:0] dest, input logic [11:0] fend);
    logic [11:0] len, p;
    beat_t b;
    len = fend - model_ptr;
    for (int i = 0; i < int'(len); i++) begin
      p = model_ptr + 12'(i);
      b.data = mem[p[10:0]];
      b.last = (i == int'(len) - 1);
      b.dest = dest;
      b.fend = fend;
      exp_q.push_back(b);
    end
    model_ptr = fend;
    sb_q.push_back({6'b0, fend, dest});
    sb_empty = 1'b0;
  endtask

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return ((k % 4) == 0) || ((k % 4) == 3);
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  task automatic observe();
    beat_t e;
    if (sb_ren) chk("sb_ren_while_empty", 32'(sb_empty), 32'd0);
    chk("fb_rptr_track", 32'(fb_rptr), 32'(model_rptr));
    if (prev_stall && !prev_rst) begin
      chk("hold_tvalid", 32'(m_tvalid), 32'd1);
      chk("hold_tdata", 32'(m_tdata), 32'(prev_data));
      chk("hold_tlast", 32'(m_tlast), 32'(prev_last));
      chk("hold_tdest", 32'(m_tdest), 32'(prev_dest));
    end
    s_sb_ren = sb_ren;
    s_fb_ren = fb_ren;
    s_addr   = fb_raddr;
    if (sb_ren) sbren_cyc.push_back(cyc);
    if (fb_ren) begin
      n_fbren++;
      if (!seen_fbren) first_addr = fb_raddr;
      seen_fbren = 1'b1;
      last_addr  = fb_raddr;
    end
    if (m_tvalid) begin
      n_valid++;
      if (!seen_valid) first_valid_cyc = cyc;
      seen_valid = 1'b1;
    end
    if (m_tvalid && m_tready && !reset) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", 32'(m_tdata), 32'(e.data));
        chk("beat_last", 32'(m_tlast), 32'(e.last));
        chk("beat_dest", 32'(m_tdest), 32'(e.dest));
        if (e.last) model_rptr = e.fend;
      end
      n_beats++;
      hs_cyc.push_back(cyc);
      beat_dest.push_back(m_tdest);
      if (m_tlast) begin
        n_tlast++;
        tlast_beat.push_back(n_beats);
      end
    end
    prev_stall = m_tvalid && !m_tready;
    prev_data  = m_tdata;
    prev_last  = m_tlast;
    prev_dest  = m_tdest;
    prev_rst   = reset;
    cyc++;
  endtask

  task automatic respond();
    if (s_sb_ren) begin
      if (sb_q.size() != 0) sb_rdata = sb_q.pop_front();
      sb_empty = (sb_q.size() == 0);
    end
    if (s_fb_ren) fb_rdata = mem[s_addr];
  endtask

  // Inputs are driven 1 time unit after the rising edge; outputs are
  // sampled mid-cycle.
  task automatic cycle();
    #4;
    observe();
    @(posedge clk);
    #1;
    respond();
  endtask

  task automatic run_desc(input vec_t v, input string nm);
    reset_stats();
    push_desc(v.dest, v.fend);
    for (int k = 0; k < 6000; k++) begin
      m_tready = ready_for(v.mode, k);
      cycle();
      if (v.exp_beats == 0 && k >= 8) break;
      if (v.exp_beats != 0 && n_tlast != 0) break;
    end
    m_tready = 1'b1;
    cycle();
    chk({nm, "_beats"}, 32'(n_beats), 32'(v.exp_beats));
    chk({nm, "_reads"}, 32'(n_fbren), 32'(v.exp_beats));
    chk({nm, "_sbren"}, 32'(sbren_cyc.size()), 32'd1);
    chk({nm, "_fb_rptr"}, 32'(fb_rptr), 32'(v.exp_rptr));
    if (v.exp_beats != 0) begin
      chk({nm, "_tlast_count"}, 32'(n_tlast), 32'd1);
      chk({nm, "_first_addr"}, 32'(first_addr), 32'(v.exp_first));
      chk({nm, "_last_addr"}, 32'(last_addr), 32'(v.exp_last));
      if (sbren_cyc.size() != 0)
        chk({nm, "_latency"}, 32'(first_valid_cyc - sbren_cyc[0]), 32'(v.exp_lat));
    end else begin
      chk({nm, "_no_tvalid"}, 32'(n_valid), 32'd0);
    end
  endtask

  vec_t vecs [7];
  vec_t post_vec;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    reset = 1'b1; sb_empty = 1'b1; sb_rdata = '0; fb_rdata = '0; m_tready = 1'b0;
    model_ptr = '0; model_rptr = '0;
    prev_stall = 1'b0; prev_rst = 1'b1; prev_data = '0; prev_last = 1'b0; prev_dest = '0;
    s_sb_ren = 1'b0; s_fb_ren = 1'b0; s_addr = '0;
    reset_stats();

    //                dest  end      mode beats first   last    rptr     lat
    vecs[0] = '{2'd2, 12'h040, 0, 64,   11'h000, 11'h03F, 12'h040, 4};
    vecs[1] = '{2'd1, 12'h050, 1, 16,   11'h040, 11'h04F, 12'h050, 4};
    vecs[2] = '{2'd3, 12'h050, 0, 0,    11'h000, 11'h000, 12'h050, 0};
    vecs[3] = '{2'd0, 12'h7FC, 2, 1964, 11'h050, 11'h7FB, 12'h7FC, 4};
    vecs[4] = '{2'd2, 12'h804, 0, 8,    11'h7FC, 11'h003, 12'h804, 4};
    vecs[5] = '{2'd1, 12'h004, 0, 2048, 11'h004, 11'h003, 12'h004, 4};
    vecs[6] = '{2'd3, 12'h005, 1, 1,    11'h004, 11'h004, 12'h005, 4};
    post_vec = '{2'd2, 12'h008, 0, 8,   11'h000, 11'h007, 12'h008, 4};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sb_ren", 32'(sb_ren), 32'd0);
    chk("rst_fb_ren", 32'(fb_ren), 32'd0);
    chk("rst_fb_raddr", 32'(fb_raddr), 32'd0);
    chk("rst_fb_rptr", 32'(fb_rptr), 32'd0);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_tlast), 32'd0);
    chk("rst_tdata", 32'(m_tdata), 32'd0);
    chk("rst_tdest", 32'(m_tdest), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_desc(vecs[i], $sformatf("vec%0d", i));

    // Zero-length descriptor followed by a 3-byte frame.
    reset_stats();
    push_desc(2'd3, model_ptr);
    push_desc(2'd1, model_ptr + 12'd3);
    for (int k = 0; k < 100 && n_tlast == 0; k++) begin m_tready = 1'b1; cycle(); end
    chk("zl_sbren_count", 32'(sbren_cyc.size()), 32'd2);
    if (sbren_cyc.size() >= 2)
      chk("zl_idle_within_3", 32'((sbren_cyc[1] - sbren_cyc[0]) <= 3), 32'd1);
    chk("zl_beats", 32'(n_beats), 32'd3);

    // Back-to-back: dest=1 len 4 then dest=3 len 5.
    reset_stats();
    push_desc(2'd1, model_ptr + 12'd4);
    push_desc(2'd3, model_ptr + 12'd5);
    for (int k = 0; k < 200 && n_tlast < 2; k++) begin m_tready = 1'b1; cycle(); end
    chk("b2b_beats", 32'(n_beats), 32'd9);
    chk("b2b_tlasts", 32'(tlast_beat.size()), 32'd2);
    if (tlast_beat.size() == 2) begin
      chk("b2b_tlast_a", 32'(tlast_beat[0]), 32'd4);
      chk("b2b_tlast_b", 32'(tlast_beat[1]), 32'd9);
    end
    if (hs_cyc.size() >= 5) begin
      chk("b2b_dest_beat4", 32'(beat_dest[3]), 32'd1);
      chk("b2b_dest_beat5", 32'(beat_dest[4]), 32'd3);
      chk("b2b_gap_le3", 32'((hs_cyc[4] - hs_cyc[3] - 1) <= 3), 32'd1);
    end

    // Reset after byte 10 of a 32-byte frame.
    m_tready = 1'b1; cycle(); cycle();
    reset_stats();
    push_desc(2'd1, model_ptr + 12'd32);
    for (int k = 0; k < 200 && n_beats < 10; k++) begin m_tready = 1'b1; cycle(); end
    chk("rstmid_pre_beats", 32'(n_beats), 32'd10);
    reset = 1'b1; m_tready = 1'b0;
    cycle();
    reset = 1'b0;
    exp_q.delete(); sb_q.delete(); sb_empty = 1'b1;
    model_ptr = '0; model_rptr = '0;
    chk("rstmid_tvalid", 32'(m_tvalid), 32'd0);
    chk("rstmid_fb_rptr", 32'(fb_rptr), 32'd0);
    chk("rstmid_fb_raddr", 32'(fb_raddr), 32'd0);
    reset_stats();
    for (int k = 0; k < 6; k++) begin m_tready = 1'b1; cycle(); end
    chk("rstmid_no_sbren", 32'(sbren_cyc.size()), 32'd0);
    chk("rstmid_no_tvalid", 32'(n_valid), 32'd0);
    run_desc(post_vec, "post_rst");

    // Randomized descriptors and backpressure.
    for (int f = 0; f < 40; f++) begin
      int nd, len;
      nd = int'($urandom_range(1, 3));
      for (int d = 0; d < nd; d++) begin
        len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
        push_desc(2'($urandom_range(0, 3)), model_ptr + 12'(len));
      end
      for (int k = 0; k < 3000; k++) begin
        m_tready = ready_for(2, k);
        cycle();
        if (exp_q.size() == 0 && sb_q.size() == 0) break;
      end
      for (int k = 0; k < 6; k++) begin m_tready = 1'($urandom_range(0, 1)); cycle(); end
    end
    for (int k = 0; k < 6; k++) begin m_tready = 1'b1; cycle(); end
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_fb_rptr", 32'(fb_rptr), 32'(model_ptr));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
